// File: rtl/tdp_bram_bytewr_if.sv
// Port bundle for tdp_bram_bytewr: clear control plus two byte-column RAM ports.
// TDP_BRAM_PARITY_EN adds the parity-injection input and per-column parity-error outputs.
interface tdp_bram_bytewr_if #(
    parameter int unsigned NB_COL = 4,
    parameter int unsigned COL_W  = 8,
    parameter int unsigned ADDR_W = 6
);
    localparam int unsigned DATA_W = NB_COL * COL_W;

    logic              clr_i;
    logic              busy_o;
    logic              ena_i;
    logic              enb_i;
    logic [NB_COL-1:0] wea_i;
    logic [NB_COL-1:0] web_i;
    logic [ADDR_W-1:0] addra_i;
    logic [ADDR_W-1:0] addrb_i;
    logic [DATA_W-1:0] dina_i;
    logic [DATA_W-1:0] dinb_i;
    logic [DATA_W-1:0] douta_o;
    logic [DATA_W-1:0] doutb_o;
    logic              valida_o;
    logic              validb_o;
    logic              collision_o;
`ifdef TDP_BRAM_PARITY_EN
    logic              inj_perr_i;
    logic [NB_COL-1:0] perra_o;
    logic [NB_COL-1:0] perrb_o;
`endif

    modport master (
`ifdef TDP_BRAM_PARITY_EN
        output inj_perr_i,
        input  perra_o, perrb_o,
`endif
        output clr_i, ena_i, enb_i, wea_i, web_i, addra_i, addrb_i, dina_i, dinb_i,
        input  busy_o, douta_o, doutb_o, valida_o, validb_o, collision_o
    );

    modport slave (
`ifdef TDP_BRAM_PARITY_EN
        input  inj_perr_i,
        output perra_o, perrb_o,
`endif
        input  clr_i, ena_i, enb_i, wea_i, web_i, addra_i, addrb_i, dina_i, dinb_i,
        output busy_o, douta_o, doutb_o, valida_o, validb_o, collision_o
    );
endinterface

// File: rtl/tdp_bram_bytewr.sv
// True dual-port RAM with byte-column write enables, hardware clear sweep and collision flag.
// Optional per-column even parity storage is enabled with TDP_BRAM_PARITY_EN.
module tdp_bram_bytewr #(
    parameter int unsigned NB_COL   = 4,
    parameter int unsigned COL_W    = 8,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned READ_LAT = 1,
    parameter int unsigned WMODE_A  = 0,
    parameter int unsigned WMODE_B  = 0
) (
    input logic              clk_i,
    input logic              rstn_i,
    tdp_bram_bytewr_if.slave bus
);
    localparam int unsigned DATA_W = NB_COL * COL_W;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;

    typedef enum logic {StClear, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;
    logic              run;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              en       [2];
    logic [NB_COL-1:0] we       [2];
    logic [ADDR_W-1:0] addr     [2];
    logic [DATA_W-1:0] din      [2];
    logic [DATA_W-1:0] out_word [2];
    logic              out_en   [2];
    logic [DATA_W-1:0] dout1_q  [2];
    logic              vld1_q   [2];
    logic              col_q;

    assign en[0]   = bus.ena_i;
    assign en[1]   = bus.enb_i;
    assign we[0]   = bus.wea_i;
    assign we[1]   = bus.web_i;
    assign addr[0] = bus.addra_i;
    assign addr[1] = bus.addrb_i;
    assign din[0]  = bus.dina_i;
    assign din[1]  = bus.dinb_i;
    assign run     = (state_q == StRun);

    assign bus.busy_o      = busy_q;
    assign bus.collision_o = col_q;

`ifdef TDP_BRAM_PARITY_EN
    logic [NB_COL-1:0] par_mem  [DEPTH];
    logic [NB_COL-1:0] out_par  [2];
    logic [NB_COL-1:0] out_perr [2];
    logic [NB_COL-1:0] perr1_q  [2];
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (&cnt_q) begin
                        state_q <= StRun;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    if (bus.clr_i) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    // Port B is applied first so port A overrides it on columns both ports enable.
    always_ff @(posedge clk_i) begin
        if (!run) begin
            mem[cnt_q] <= '0;
`ifdef TDP_BRAM_PARITY_EN
            par_mem[cnt_q] <= '0;
`endif
        end else begin
            for (int p = 1; p >= 0; p--) begin
                if (en[p]) begin
                    for (int k = 0; k < NB_COL; k++) begin
                        if (we[p][k]) begin
                            mem[addr[p]][k*COL_W +: COL_W] <= din[p][k*COL_W +: COL_W];
`ifdef TDP_BRAM_PARITY_EN
                            par_mem[addr[p]][k] <= (^din[p][k*COL_W +: COL_W])
                                                   ^ ((k == 0) && bus.inj_perr_i);
`endif
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            int unsigned mode;
            mode        = (p == 0) ? WMODE_A : WMODE_B;
            out_en[p]   = 1'b0;
            out_word[p] = mem[addr[p]];
`ifdef TDP_BRAM_PARITY_EN
            out_par[p]  = par_mem[addr[p]];
`endif
            if (run && en[p]) begin
                if (we[p] == '0 || mode == 0) begin
                    out_en[p] = 1'b1;
                end else if (mode == 1) begin
                    out_en[p] = 1'b1;
                    for (int k = 0; k < NB_COL; k++) begin
                        if (we[p][k]) begin
                            out_word[p][k*COL_W +: COL_W] = din[p][k*COL_W +: COL_W];
`ifdef TDP_BRAM_PARITY_EN
                            out_par[p][k] = (^din[p][k*COL_W +: COL_W])
                                            ^ ((k == 0) && bus.inj_perr_i);
`endif
                        end
                    end
                end
            end
`ifdef TDP_BRAM_PARITY_EN
            for (int k = 0; k < NB_COL; k++) begin
                out_perr[p][k] = (^out_word[p][k*COL_W +: COL_W]) ^ out_par[p][k];
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_q <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                dout1_q[p] <= '0;
                vld1_q[p]  <= 1'b0;
`ifdef TDP_BRAM_PARITY_EN
                perr1_q[p] <= '0;
`endif
            end
        end else begin
            col_q <= run && en[0] && en[1] && (addr[0] == addr[1]) && ((we[0] | we[1]) != '0);
            for (int p = 0; p < 2; p++) begin
                vld1_q[p] <= out_en[p];
                if (out_en[p]) begin
                    dout1_q[p] <= out_word[p];
`ifdef TDP_BRAM_PARITY_EN
                    perr1_q[p] <= out_perr[p];
`endif
                end
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] dout2_q [2];
        logic              vld2_q  [2];
`ifdef TDP_BRAM_PARITY_EN
        logic [NB_COL-1:0] perr2_q [2];
`endif
        always_ff @(posedge clk_i or negedge rstn_i) begin
            for (int p = 0; p < 2; p++) begin
                if (!rstn_i) begin
                    dout2_q[p] <= '0;
                    vld2_q[p]  <= 1'b0;
`ifdef TDP_BRAM_PARITY_EN
                    perr2_q[p] <= '0;
`endif
                end else begin
                    dout2_q[p] <= dout1_q[p];
                    vld2_q[p]  <= vld1_q[p];
`ifdef TDP_BRAM_PARITY_EN
                    perr2_q[p] <= perr1_q[p];
`endif
                end
            end
        end
        assign bus.douta_o  = dout2_q[0];
        assign bus.doutb_o  = dout2_q[1];
        assign bus.valida_o = vld2_q[0];
        assign bus.validb_o = vld2_q[1];
`ifdef TDP_BRAM_PARITY_EN
        assign bus.perra_o  = perr2_q[0];
        assign bus.perrb_o  = perr2_q[1];
`endif
    end else begin : g_lat1
        assign bus.douta_o  = dout1_q[0];
        assign bus.doutb_o  = dout1_q[1];
        assign bus.valida_o = vld1_q[0];
        assign bus.validb_o = vld1_q[1];
`ifdef TDP_BRAM_PARITY_EN
        assign bus.perra_o  = perr1_q[0];
        assign bus.perrb_o  = perr1_q[1];
`endif
    end
endmodule

// File: tb/tb_tdp_bram_bytewr.sv
// Scoreboard bench: two DUT builds (READ_FIRST/lat1 and WRITE_FIRST+NO_CHANGE/lat2) share
// stimulus; an array-based memory model predicts every read, busy and collision output.
module tb_tdp_bram_bytewr;
    localparam int unsigned NB_COL = 4;
    localparam int unsigned COL_W  = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 64;
    localparam int MODE [4] = '{0, 0, 1, 2};
    localparam int LAT  [4] = '{1, 1, 2, 2};

    typedef struct {int due; logic [31:0] data;} exp_t;
    typedef struct {int due; logic busy; logic col;} st_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    tdp_bram_bytewr_if #(.NB_COL(NB_COL), .COL_W(COL_W), .ADDR_W(ADDR_W)) bus0 ();
    tdp_bram_bytewr_if #(.NB_COL(NB_COL), .COL_W(COL_W), .ADDR_W(ADDR_W)) bus1 ();

    assign bus1.clr_i   = bus0.clr_i;
    assign bus1.ena_i   = bus0.ena_i;
    assign bus1.enb_i   = bus0.enb_i;
    assign bus1.wea_i   = bus0.wea_i;
    assign bus1.web_i   = bus0.web_i;
    assign bus1.addra_i = bus0.addra_i;
    assign bus1.addrb_i = bus0.addrb_i;
    assign bus1.dina_i  = bus0.dina_i;
    assign bus1.dinb_i  = bus0.dinb_i;
`ifdef TDP_BRAM_PARITY_EN
    initial bus0.inj_perr_i = 1'b0;
    assign bus1.inj_perr_i = bus0.inj_perr_i;
`endif

    tdp_bram_bytewr #(.NB_COL(NB_COL), .COL_W(COL_W), .ADDR_W(ADDR_W), .READ_LAT(1),
                      .WMODE_A(0), .WMODE_B(0)) u0 (.clk_i(clk), .rstn_i(rstn), .bus(bus0));
    tdp_bram_bytewr #(.NB_COL(NB_COL), .COL_W(COL_W), .ADDR_W(ADDR_W), .READ_LAT(2),
                      .WMODE_A(1), .WMODE_B(2)) u1 (.clk_i(clk), .rstn_i(rstn), .bus(bus1));

    exp_t        sbq [4][$];
    st_t         stq [$];
    st_t         cur_st;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] lastv [4];
    int          clear_left;
    int          cyc  = 0;
    int          nvec = 0;
    int          nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (we[k]) r[k*8 +: 8] = din[k*8 +: 8];
        return r;
    endfunction

    // Applies one set of inputs and predicts the effect of the edge that captures them.
    task automatic step(input logic ea, input logic [3:0] wa, input logic [5:0] aa,
                        input logic [31:0] da, input logic eb, input logic [3:0] wb,
                        input logic [5:0] ab, input logic [31:0] db, input logic clr);
        logic        e [2];
        logic [3:0]  w [2];
        logic [31:0] d [2];
        logic [31:0] old [2];
        exp_t        x;
        st_t         s;
        bus0.ena_i = ea; bus0.wea_i = wa; bus0.addra_i = aa; bus0.dina_i = da;
        bus0.enb_i = eb; bus0.web_i = wb; bus0.addrb_i = ab; bus0.dinb_i = db;
        bus0.clr_i = clr;
        s.due = cyc + 1;
        if (clear_left > 0) begin
            clear_left--;
            s.busy = (clear_left > 0);
            s.col  = 1'b0;
        end else begin
            e[0] = ea; w[0] = wa; d[0] = da; old[0] = model_mem[aa];
            e[1] = eb; w[1] = wb; d[1] = db; old[1] = model_mem[ab];
            s.col  = ea && eb && (aa == ab) && ((wa | wb) != 4'b0);
            s.busy = clr;
            for (int i = 0; i < 4; i++) begin
                int p;
                p = i % 2;
                x.due = cyc + LAT[i];
                if (e[p]) begin
                    if (w[p] == 4'b0 || MODE[i] == 0) begin
                        x.data = old[p];
                        sbq[i].push_back(x);
                    end else if (MODE[i] == 1) begin
                        x.data = merge(old[p], d[p], w[p]);
                        sbq[i].push_back(x);
                    end
                end
            end
            if (eb) model_mem[ab] = merge(model_mem[ab], db, wb);
            if (ea) model_mem[aa] = merge(model_mem[aa], da, wa);
            if (clr) begin
                clear_left = DEPTH;
                for (int j = 0; j < DEPTH; j++) model_mem[j] = '0;
            end
        end
        stq.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 4'h0, 6'd0, 0, 0, 4'h0, 6'd0, 0, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus0.ena_i = 0; bus0.enb_i = 0; bus0.wea_i = 0; bus0.web_i = 0; bus0.clr_i = 0;
        bus0.addra_i = 0; bus0.addrb_i = 0; bus0.dina_i = 0; bus0.dinb_i = 0;
        for (int i = 0; i < 4; i++) begin
            sbq[i].delete();
            lastv[i] = '0;
        end
        stq.delete();
        clear_left = DEPTH;
        for (int j = 0; j < DEPTH; j++) model_mem[j] = '0;
        @(negedge clk);
        cmp("rst_douta0", bus0.douta_o, 0);  cmp("rst_doutb0", bus0.doutb_o, 0);
        cmp("rst_douta1", bus1.douta_o, 0);  cmp("rst_doutb1", bus1.doutb_o, 0);
        cmp("rst_valid0", {bus0.valida_o, bus0.validb_o}, 0);
        cmp("rst_valid1", {bus1.valida_o, bus1.validb_o}, 0);
        cmp("rst_col", {bus0.collision_o, bus1.collision_o}, 0);
        cmp("rst_busy", {bus0.busy_o, bus1.busy_o}, 2'b11);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic chk_port(input int i, input logic v, input logic [31:0] d);
        exp_t e;
        if (v) begin
            if (sbq[i].size() == 0 || sbq[i][0].due != cyc) begin
                nvec++; nerr++;
                $display("FAIL valid%0d: got unexpected valid=1 required 0 (cycle %0d)", i, cyc);
                lastv[i] = d;
            end else begin
                e = sbq[i].pop_front();
                cmp($sformatf("dout%0d", i), d, e.data);
                lastv[i] = e.data;
            end
        end else begin
            if (sbq[i].size() > 0 && sbq[i][0].due == cyc) begin
                e = sbq[i].pop_front();
                nvec++; nerr++;
                $display("FAIL valid%0d: got 0 required 1 for data %h (cycle %0d)", i, e.data, cyc);
            end
            cmp($sformatf("hold%0d", i), d, lastv[i]);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            chk_port(0, bus0.valida_o, bus0.douta_o);
            chk_port(1, bus0.validb_o, bus0.doutb_o);
            chk_port(2, bus1.valida_o, bus1.douta_o);
            chk_port(3, bus1.validb_o, bus1.doutb_o);
            if (stq.size() > 0 && stq[0].due == cyc) begin
                cur_st = stq.pop_front();
                cmp("busy0", bus0.busy_o, cur_st.busy);
                cmp("busy1", bus1.busy_o, cur_st.busy);
                cmp("col0", bus0.collision_o, cur_st.col);
                cmp("col1", bus1.collision_o, cur_st.col);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        // Enables held during the clear sweep must be ignored; then memory reads as zero.
        for (int i = 0; i < 64; i++) step(1, 4'h0, 6'd5, 0, 1, 4'h0, 6'd5, 0, 0);
        step(1, 4'h0, 6'd5, 0, 0, 4'h0, 6'd0, 0, 0);
        // Byte-column merge.
        step(1, 4'hF, 6'd3, 32'hAABBCCDD, 0, 4'h0, 6'd0, 0, 0);
        step(1, 4'h5, 6'd3, 32'h11223344, 0, 4'h0, 6'd0, 0, 0);
        step(1, 4'h0, 6'd3, 0, 0, 4'h0, 6'd0, 0, 0);
        // Write-cycle output per write mode; port B exercises NO_CHANGE on u1.
        step(1, 4'hF, 6'd7, 32'hDEADBEEF, 1, 4'hF, 6'd8, 32'h01234567, 0);
        idle(2);
        // Same-address collision: A wins on column 0, B supplies the rest.
        step(1, 4'h1, 6'd9, 32'h000000FF, 1, 4'hF, 6'd9, 32'hFFFFFF00, 0);
        step(1, 4'h0, 6'd9, 0, 1, 4'h0, 6'd9, 0, 0);
        // Write while the other port reads the same address.
        step(1, 4'hF, 6'd9, 32'h55AA55AA, 1, 4'h0, 6'd9, 0, 0);
        // Back-to-back reads through the pipeline.
        step(0, 4'h0, 6'd0, 0, 1, 4'hF, 6'd1, 32'h1, 0);
        step(0, 4'h0, 6'd0, 0, 1, 4'hF, 6'd2, 32'h2, 0);
        step(0, 4'h0, 6'd0, 0, 1, 4'hF, 6'd3, 32'h3, 0);
        step(1, 4'h0, 6'd1, 0, 0, 4'h0, 6'd0, 0, 0);
        step(1, 4'h0, 6'd2, 0, 0, 4'h0, 6'd0, 0, 0);
        step(1, 4'h0, 6'd3, 0, 0, 4'h0, 6'd0, 0, 0);
        idle(3);
        // Clear from RUN, with a read on the same edge.
        step(1, 4'h0, 6'd7, 0, 0, 4'h0, 6'd0, 0, 1);
        idle(66);
        step(1, 4'h0, 6'd7, 0, 1, 4'h0, 6'd3, 0, 0);
        // clr ignored mid-sweep, then reset mid-sweep restarts the full sweep.
        do_reset();
        idle(20);
        step(0, 4'h0, 6'd0, 0, 0, 4'h0, 6'd0, 0, 1);
        idle(10);
        do_reset();
        idle(66);
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] aa, ab;
            aa = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
            ab = ($urandom_range(0, 2) == 0) ? aa : 6'($urandom_range(0, 7));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) ? 4'($urandom) : 4'h0, aa,
                 $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) ? 4'($urandom) : 4'h0, ab, $urandom,
                 $urandom_range(0, 399) == 0);
        end
        idle(4);
        for (int i = 0; i < 4; i++) cmp($sformatf("drain%0d", i), sbq[i].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/tdp_bram_bytewr.md
Name: tdp_bram_bytewr

Overview:
Second-generation true dual-port block RAM for the NLA memory subsystem. It is generalised to byte-column write enables, a selectable read latency and a per-port write mode. It adds a hardware clear sequencer, read-valid tracking and same-address collision detection. It sits between the approximation-engine datapath and LUT/coefficient storage, where two independent agents access a shared table.

Parameters:
NB_COL, 4, number of write-enable columns per word
COL_W, 8, bits per column; DATA_W = NB_COL*COL_W
ADDR_W, 6, address bits; DEPTH = 2**ADDR_W
READ_LAT, 1, read latency in cycles, legal values 1 or 2
WMODE_A, 0, port A write mode: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE
WMODE_B, 0, port B write mode, same encoding

Ports:
clk_i  in  1  clock, all logic on rising edge
rstn_i  in  1  asynchronous active-low reset
clr_i  in  1  one-cycle request to zero the whole memory
busy_o  out  1  high while the clear sequence runs
ena_i / enb_i  in  1  port A / B access enable
wea_i / web_i  in  NB_COL  per-column write enable; all zero means read
addra_i / addrb_i  in  ADDR_W  port address
dina_i / dinb_i  in  DATA_W  write data
douta_o / doutb_o  out  DATA_W  read data
valida_o / validb_o  out  1  douta_o / doutb_o updated this cycle
collision_o  out  1  same-address conflict detected, registered pulse

Behaviour:
- Reset (asynchronous, rstn_i low):
  - douta_o, doutb_o, valid*_o and collision_o go to 0.
  - FSM goes to CLEAR with the clear address counter at 0, and busy_o = 1.
  - Memory contents are otherwise unaffected by reset itself; CLEAR zeroes them.
- FSM states:
  - CLEAR: writes zero to address cnt each cycle, then cnt++. After writing DEPTH-1 it moves to RUN, so CLEAR lasts exactly DEPTH cycles.
  - RUN: normal operation. clr_i = 1 moves to CLEAR with cnt = 0 on the next edge.
  - clr_i asserted while already in CLEAR is ignored; the sweep does not restart.
  - Reset asserted mid-clear restarts the sweep at 0.
- In CLEAR:
  - All port enables are ignored: no writes, no reads, valid*_o = 0, collision_o = 0.
  - dout*_o hold their last value.
- Write (en = 1, we != 0): only columns with we[k] = 1 are updated; other columns keep stored data.
- Read (en = 1, we = 0): data appears on dout READ_LAT cycles after the request edge, with valid high that same cycle.
- Write-cycle output, per port WMODE:
  - READ_FIRST: dout = old word, valid pulses.
  - WRITE_FIRST: dout = merged new word, valid pulses.
  - NO_CHANGE: dout holds, no valid.
- READ_LAT = 2: one additional output register stage. dout and valid are both delayed one further cycle; the pipeline is fully pipelined, one access per cycle per port.
- Collision: ena_i & enb_i & addra_i == addrb_i & (wea_i | web_i) != 0 drives collision_o = 1 exactly one cycle later for one cycle.
  - Both ports write the same address: port A wins on columns both enable. Columns written only by B take B's data.
  - One port writes while the other reads the same address: the reader gets the old word.
- Write to different addresses on the same cycle: both complete independently.
- Address wrap: the address is used modulo DEPTH; no out-of-range check.

Optional Feature:
Macro TDP_BRAM_PARITY_EN.
- Defined:
  - One even-parity bit per column is stored alongside the data, computed on write.
  - Added outputs perra_o / perrb_o (NB_COL wide) are aligned with valid. A bit is set for a column whose recomputed parity mismatches.
  - CLEAR writes correct parity for zero, i.e. 0.
  - Added input inj_perr_i (1 bit) flips stored parity of column 0 on any write, for test.
- Undefined: no parity storage, perr ports and inj_perr_i are absent, and memory width is DATA_W.

Test Plan:
- Release reset, ena_i = 1 during CLEAR -> busy_o high exactly 64 cycles (ADDR_W = 6), no valida_o; then read addr 5 -> douta_o = 0x00000000, valida_o 1 cycle later.
- Port A write addr 3 data 0xAABBCCDD wea = 4'b1111, then wea = 4'b0101 data 0x11223344 -> read addr 3 returns 0xAA22CC44.
- WMODE_A = 1, write addr 7 0xDEADBEEF -> douta_o = 0xDEADBEEF, valida_o 1 next cycle. WMODE_A = 2 -> douta_o unchanged, valida_o 0.
- Same cycle A write 0x000000FF wea = 4'b0001 and B write 0xFFFFFF00 web = 4'b1111 to addr 9 -> collision_o pulse next cycle; read addr 9 returns 0xFFFFFFFF.
- READ_LAT = 2, back-to-back reads of addr 1,2,3 holding 0x1,0x2,0x3 -> dout 0x1,0x2,0x3 on cycles +2,+3,+4, valid high all three.
- clr_i pulsed at cnt = 20 during CLEAR, then rstn_i low mid-sweep -> sweep restarts at 0, busy_o stays high a full DEPTH cycles after reset release.
